// File: rtl/online_minmax_serializer.sv
// online_minmax_serializer
//   Digit-serial transmitter/collector for the online min/max comparator tree.
//   Captures one set of N_INPUTS operand words, streams them MSB-first (one
//   digit per channel per cycle) with a start strobe, gathers the returning
//   result digits after TREE_LATENCY cycles and presents the collected word
//   on a valid/ready output. One transaction in flight at a time.
//
//   Optional feature: define MINMAX_SER_SELFCHECK_EN to add a local sequential
//   min/max reducer; io_check_err then flags a tree result that disagrees with it.
//   Without the macro io_check_err is tied to 0.
//
// Ports
//   clock, reset_n      clock (rising edge), asynchronous active-low reset
//   io_in_valid/ready   operand-set handshake
//   io_in_data          operand words, channel i at [i*WIDTH +: WIDTH]
//   io_in_max           1 = max, 0 = min; captured with the data
//   io_ser_start        digit-valid strobe to the tree
//   io_ser_max          captured operation select
//   io_ser_digits       current digit of each channel (bit i = channel i)
//   io_ser_result       result digit returned by the tree
//   io_out_valid/ready  collected-result handshake
//   io_out_data         collected result word
//   io_check_err        self-check mismatch flag
module online_minmax_serializer #(
    parameter int unsigned N_INPUTS     = 6,
    parameter int unsigned WIDTH        = 3,
    parameter int unsigned TREE_LATENCY = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         io_in_valid,
    output logic                         io_in_ready,
    input  logic [N_INPUTS*WIDTH-1:0]    io_in_data,
    input  logic                         io_in_max,
    output logic                         io_ser_start,
    output logic                         io_ser_max,
    output logic [N_INPUTS-1:0]          io_ser_digits,
    input  logic                         io_ser_result,
    output logic                         io_out_valid,
    input  logic                         io_out_ready,
    output logic [WIDTH-1:0]             io_out_data,
    output logic                         io_check_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] W_CNT   = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        sreg_q [N_INPUTS];
    logic [WIDTH-1:0]        sreg_d [N_INPUTS];
    logic [N_INPUTS-1:0]     digits_q, digits_d;
    logic [CW-1:0]           dcnt_q, dcnt_d;
    logic [CW-1:0]           rcnt_q, rcnt_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic [TREE_LATENCY-1:0] dly_q, dly_d;
    logic                    in_ready_q, in_ready_d;
    logic                    ser_start_q, ser_start_d;
    logic                    ser_max_q, ser_max_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;

    assign accept = (state_q == IDLE) && io_in_valid;

    // Next-state and next-output logic; outputs are registered from state_d
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        digits_d  = '0;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        res_d     = res_q;
        ser_max_d = ser_max_q;

        // Valid delay line mirrors the tree latency; only its last stage qualifies io_ser_result
        dly_d[0] = ser_start_q;
        for (int j = 1; j < int'(TREE_LATENCY); j++) begin
            dly_d[j] = dly_q[j-1];
        end

        // Result digits arrive MSB-first, so shift in at the LSB
        if (dly_q[TREE_LATENCY-1]) begin
            res_d  = {res_q[WIDTH-2:0], io_ser_result};
            rcnt_d = rcnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (io_in_valid) begin
                    // Digit 0 goes straight to the output register; keep the rest pre-shifted
                    for (int i = 0; i < int'(N_INPUTS); i++) begin
                        digits_d[i] = io_in_data[i*WIDTH + WIDTH - 1];
                        sreg_d[i]   = {io_in_data[i*WIDTH +: WIDTH-1], 1'b0};
                    end
                    dcnt_d    = CNT_ONE;
                    rcnt_d    = '0;
                    res_d     = '0;
                    ser_max_d = io_in_max;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (dcnt_q == W_CNT) begin
                    state_d = DRAIN;
                end else begin
                    for (int i = 0; i < int'(N_INPUTS); i++) begin
                        digits_d[i] = sreg_q[i][WIDTH-1];
                        sreg_d[i]   = {sreg_q[i][WIDTH-2:0], 1'b0};
                    end
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (rcnt_d == W_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        ser_start_d = (state_d == SHIFT);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                sreg_q[i] <= '0;
            end
            digits_q    <= '0;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            res_q       <= '0;
            dly_q       <= '0;
            in_ready_q  <= 1'b1;
            ser_start_q <= 1'b0;
            ser_max_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            digits_q    <= digits_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            res_q       <= res_d;
            dly_q       <= dly_d;
            in_ready_q  <= in_ready_d;
            ser_start_q <= ser_start_d;
            ser_max_q   <= ser_max_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io_in_ready   = in_ready_q;
    assign io_ser_start  = ser_start_q;
    assign io_ser_max    = ser_max_q;
    assign io_ser_digits = digits_q;
    assign io_out_valid  = out_valid_q;
    assign io_out_data   = res_q;

`ifdef MINMAX_SER_SELFCHECK_EN
    localparam int unsigned NQ = N_INPUTS - 1;
    localparam int unsigned RW = $clog2(N_INPUTS);

    logic [WIDTH-1:0] opq_q [NQ];
    logic [WIDTH-1:0] opq_d [NQ];
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             err_q, err_d;

    // Sequential reducer: channel 0 seeds the accumulator, then one compare per cycle
    always_comb begin
        opq_d = opq_q;
        acc_d = acc_q;
        rem_d = rem_q;
        if (accept) begin
            acc_d = io_in_data[WIDTH-1:0];
            for (int j = 0; j < int'(NQ); j++) begin
                opq_d[j] = io_in_data[(j+1)*WIDTH +: WIDTH];
            end
            rem_d = RW'(NQ);
        end else if ((state_q != IDLE) && (rem_q != '0)) begin
            if (ser_max_q ? (opq_q[0] > acc_q) : (opq_q[0] < acc_q)) begin
                acc_d = opq_q[0];
            end
            for (int j = 0; j < int'(NQ) - 1; j++) begin
                opq_d[j] = opq_q[j+1];
            end
            rem_d = rem_q - RW'(1);
        end
        err_d = (state_d == DONE) && (rem_d == '0) && (res_d != acc_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < int'(NQ); j++) begin
                opq_q[j] <= '0;
            end
            acc_q <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            opq_q <= opq_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            err_q <= err_d;
        end
    end

    assign io_check_err = err_q;
`else
    assign io_check_err = 1'b0;
`endif

endmodule

// File: tb/tb_online_minmax_serializer.sv
// Self-checking bench for online_minmax_serializer with a behavioural tree model.
module tb_online_minmax_serializer;

    localparam int unsigned N  = 6;
    localparam int unsigned W  = 3;
    localparam int unsigned TL = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [N*W-1:0]   io_in_data = '0;
    logic             io_in_max = 1'b0;
    logic             io_ser_start;
    logic             io_ser_max;
    logic [N-1:0]     io_ser_digits;
    logic             io_ser_result;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [W-1:0]     io_out_data;
    logic             io_check_err;

    always #5 clock = ~clock;

    online_minmax_serializer #(
        .N_INPUTS    (N),
        .WIDTH       (W),
        .TREE_LATENCY(TL)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_data   (io_in_data),
        .io_in_max    (io_in_max),
        .io_ser_start (io_ser_start),
        .io_ser_max   (io_ser_max),
        .io_ser_digits(io_ser_digits),
        .io_ser_result(io_ser_result),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_data  (io_out_data),
        .io_check_err (io_check_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Tree model: min/max of prefixes equals the prefix of the min/max, so each
    // result digit is the LSB of the extremum of the prefixes seen so far.
    logic [TL-1:0] tpipe;
    int            pref [N];
    int            np_t [N];
    int            m_t;
    int            didx;
    bit            corrupt = 1'b0;
    logic          rbit_t;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            np_t[i] = pref[i] * 2 + int'(io_ser_digits[i]);
        end
        m_t = np_t[0];
        for (int i = 1; i < int'(N); i++) begin
            if (io_ser_max ? (np_t[i] > m_t) : (np_t[i] < m_t)) m_t = np_t[i];
        end
        rbit_t = m_t[0] ^ (corrupt && (didx == 1));
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tpipe <= '0;
            didx  <= 0;
            for (int i = 0; i < int'(N); i++) pref[i] <= 0;
        end else begin
            if (io_ser_start) begin
                for (int i = 0; i < int'(N); i++) pref[i] <= np_t[i];
                didx <= didx + 1;
            end else begin
                for (int i = 0; i < int'(N); i++) pref[i] <= 0;
                didx <= 0;
            end
            // Garbage between digits must be ignored by the DUT
            tpipe <= {tpipe[TL-2:0], io_ser_start ? rbit_t : 1'($urandom)};
        end
    end

    assign io_ser_result = tpipe[TL-1];

    logic [W-1:0] ops [N];

    // Run one transaction: send ops, check digits, latency, result, backpressure, release
    task automatic run_txn(input bit mx, input bit corr, input int hold);
        logic [W-1:0]   exp_res;
        logic [W-1:0]   exp_data;
        logic [N*W-1:0] pk;
        logic [N-1:0]   edig;
        logic [W-1:0]   held;
        bit             exp_err;
        int             cnt;
        exp_res = ops[0];
        for (int i = 1; i < int'(N); i++) begin
            if (mx ? (ops[i] > exp_res) : (ops[i] < exp_res)) exp_res = ops[i];
        end
        for (int i = 0; i < int'(N); i++) pk[i*W +: W] = ops[i];
        exp_data = corr ? (exp_res ^ W'(1 << (W - 2))) : exp_res;
`ifdef MINMAX_SER_SELFCHECK_EN
        exp_err = corr;
`else
        exp_err = 1'b0;
`endif
        cnt = 0;
        @(negedge clock);
        while (!io_in_ready && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        check("in_ready_wait", 32'(io_in_ready), 32'd1);
        io_in_data  = pk;
        io_in_max   = mx;
        io_in_valid = 1'b1;
        corrupt     = corr;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        io_in_data  = (N*W)'($urandom);
        io_in_max   = ~mx;
        for (int k = 0; k < int'(W); k++) begin
            @(negedge clock);
            for (int i = 0; i < int'(N); i++) edig[i] = ops[i][W-1-k];
            check("digits", 32'(io_ser_digits), 32'(edig));
            check("ser_start", 32'(io_ser_start), 32'd1);
            check("ser_max", 32'(io_ser_max), 32'(mx));
            check("in_ready_busy", 32'(io_in_ready), 32'd0);
        end
        cnt = W;
        while (!io_out_valid && cnt < 60) begin
            @(negedge clock);
            cnt++;
            if (!io_out_valid) begin
                check("digits_idle", 32'(io_ser_digits), 32'd0);
            end
        end
        check("latency", 32'(cnt), 32'(W + TL + 1));
        check("out_data", 32'(io_out_data), 32'(exp_data));
        check("check_err", 32'(io_check_err), 32'(exp_err));
        check("ser_max_done", 32'(io_ser_max), 32'(mx));
        held = io_out_data;
        for (int h = 0; h < hold; h++) begin
            io_in_valid = 1'($urandom);
            io_in_data  = (N*W)'($urandom);
            @(negedge clock);
            check("hold_valid", 32'(io_out_valid), 32'd1);
            check("hold_data", 32'(io_out_data), 32'(held));
            check("hold_in_ready", 32'(io_in_ready), 32'd0);
            check("hold_err", 32'(io_check_err), 32'(exp_err));
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        check("release_in_ready", 32'(io_in_ready), 32'd1);
        check("release_out_valid", 32'(io_out_valid), 32'd0);
        corrupt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset_n is held low
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(io_in_ready), 32'd1);
        check("rst_ser_start", 32'(io_ser_start), 32'd0);
        check("rst_ser_max", 32'(io_ser_max), 32'd0);
        check("rst_digits", 32'(io_ser_digits), 32'd0);
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_out_data", 32'(io_out_data), 32'd0);
        check("rst_check_err", 32'(io_check_err), 32'd0);
        reset_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check("idle_state", {29'd0, io_in_ready, io_out_valid, |io_ser_digits}, 32'b100);
        end

        // Directed min, max, and max with backpressure
        ops[0] = 3'd5; ops[1] = 3'd3; ops[2] = 3'd6;
        ops[3] = 3'd1; ops[4] = 3'd7; ops[5] = 3'd2;
        run_txn(1'b0, 1'b0, 0);
        run_txn(1'b1, 1'b0, 0);
        run_txn(1'b1, 1'b0, 10);

        // Randomized transactions, including all-equal and extreme sets
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (t == 0)      ops[i] = '0;
                else if (t == 1) ops[i] = '1;
                else if (t == 2) ops[i] = W'(5);
                else             ops[i] = W'($urandom);
            end
            run_txn(1'($urandom), 1'b0, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of SHIFT aborts the transaction
        @(negedge clock);
        for (int i = 0; i < int'(N); i++) ops[i] = W'($urandom);
        io_in_data  = {ops[5], ops[4], ops[3], ops[2], ops[1], ops[0]};
        io_in_max   = 1'b0;
        io_in_valid = 1'b1;
        check("abort_in_ready", 32'(io_in_ready), 32'd1);
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_ser_start", 32'(io_ser_start), 32'd0);
        check("abort_in_ready_now", 32'(io_in_ready), 32'd1);
        check("abort_digits", 32'(io_ser_digits), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            check("abort_no_valid", 32'(io_out_valid), 32'd0);
        end

        // Corrupted tree digit 1: collected word differs from the true minimum
        ops[0] = 3'd5; ops[1] = 3'd3; ops[2] = 3'd6;
        ops[3] = 3'd1; ops[4] = 3'd7; ops[5] = 3'd2;
        run_txn(1'b0, 1'b1, 2);
        run_txn(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
